interleaver_ctrl: RTL and testbench

Frame sequencer for the 802.11a block interleaver. It sits between the convolutional encoder/puncturer and the interleaver. Per OFDM symbol it accepts exactly NCBPS/2 coded bit pairs from upstream through a valid/ready handshake, zero-pads the final symbol after the last data pair, and issues the post-fill drain beats. It also latches modulation for the whole frame and reports symbol progress and frame completion.

---
 rtl/interleaver_ctrl_pkg.sv | 40 ++++
 rtl/interleaver_ctrl.sv | 149 ++++++++++++++
 tb/tb_interleaver_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/interleaver_ctrl_pkg.sv
// Shared types and constants for the 802.11a interleaver frame sequencer.
// Holds the controller state encoding and the pairs-per-symbol lookup by modulation.
package interleaver_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PAD,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] MOD_BPSK  = 2'd0;
   localparam logic [1:0] MOD_QPSK  = 2'd1;
   localparam logic [1:0] MOD_16QAM = 2'd2;
   localparam logic [1:0] MOD_64QAM = 2'd3;

   localparam int BEAT_W = 8;

   localparam logic [BEAT_W-1:0] PAIRS_BPSK  = 8'd24;
   localparam logic [BEAT_W-1:0] PAIRS_QPSK  = 8'd48;
   localparam logic [BEAT_W-1:0] PAIRS_16QAM = 8'd96;
   localparam logic [BEAT_W-1:0] PAIRS_64QAM = 8'd144;

   localparam int DRAIN_BEATS_DEF = 8;

   // Coded bit pairs per OFDM symbol (NCBPS/2) for a modulation code.
   function automatic logic [BEAT_W-1:0] pairs_per_sym(input logic [1:0] mod);
      logic [BEAT_W-1:0] p;
      case (mod)
         MOD_BPSK:  p = PAIRS_BPSK;
         MOD_QPSK:  p = PAIRS_QPSK;
         MOD_16QAM: p = PAIRS_16QAM;
         MOD_64QAM: p = PAIRS_64QAM;
         default:   p = PAIRS_BPSK;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/interleaver_ctrl.sv
// Frame sequencer for the 802.11a block interleaver: fills each symbol with
// upstream pairs, zero-pads the final symbol, issues drain beats and flags frame end.
module interleaver_ctrl
   import interleaver_ctrl_pkg::*;
#(
   parameter int DRAIN_BEATS = DRAIN_BEATS_DEF,
   parameter int NSYM_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic [1:0]        mod_in,
   input  logic [NSYM_W-1:0] nsym_in,
   input  logic              in_valid,
   input  logic [1:0]        in_x,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              il_run,
   output logic [1:0]        il_x,
   output logic [1:0]        il_mod,
   output logic              busy,
   output logic [NSYM_W-1:0] sym_idx,
   output logic              frame_done,
   output logic              frame_err,
   output state_t            dbg_state
);

   localparam int DRAIN_W = $clog2(DRAIN_BEATS + 1);

   // Upstream handshake: a pair transfers in any cycle where in_valid and in_ready
   // are both high; in_valid must not depend on in_ready, in_ready only rises in FILL.

   state_t            state, state_n;
   logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
   logic [DRAIN_W-1:0] drain_cnt, drain_cnt_n;
   logic [1:0]        mod_q, mod_n;
   logic [NSYM_W-1:0] nsym_q, nsym_n;
   logic [NSYM_W-1:0] sym_q, sym_n;
   logic              last_seen, last_seen_n;
   logic              zero_err_q, zero_err_n;
   logic [BEAT_W-1:0] p_last;

   assign p_last = pairs_per_sym(mod_q) - BEAT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         drain_cnt  <= '0;
         mod_q      <= '0;
         nsym_q     <= '0;
         sym_q      <= '0;
         last_seen  <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         state      <= state_n;
         beat_cnt   <= beat_cnt_n;
         drain_cnt  <= drain_cnt_n;
         mod_q      <= mod_n;
         nsym_q     <= nsym_n;
         sym_q      <= sym_n;
         last_seen  <= last_seen_n;
         zero_err_q <= zero_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      beat_cnt_n  = beat_cnt;
      drain_cnt_n = drain_cnt;
      mod_n       = mod_q;
      nsym_n      = nsym_q;
      sym_n       = sym_q;
      last_seen_n = last_seen;
      zero_err_n  = 1'b0;
      in_ready    = 1'b0;
      il_run      = 1'b0;
      il_x        = 2'b00;

      case (state)
         ST_IDLE: begin
            if (frame_start) begin
               if (nsym_in != '0) begin
                  state_n     = ST_FILL;
                  mod_n       = mod_in;
                  nsym_n      = nsym_in;
                  sym_n       = '0;
                  beat_cnt_n  = '0;
                  drain_cnt_n = '0;
                  last_seen_n = 1'b0;
               end else begin
                  zero_err_n = 1'b1;
               end
            end
         end
         ST_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               il_run     = 1'b1;
               il_x       = in_x;
               beat_cnt_n = beat_cnt + BEAT_W'(1);
               if (beat_cnt == p_last) begin
                  state_n     = ST_DRAIN;
                  last_seen_n = last_seen | in_last;
               end else if (in_last) begin
                  state_n     = ST_PAD;
                  last_seen_n = 1'b1;
               end
            end
         end
         ST_PAD: begin
            il_run     = 1'b1;
            beat_cnt_n = beat_cnt + BEAT_W'(1);
            if (beat_cnt == p_last) state_n = ST_DRAIN;
         end
         ST_DRAIN: begin
            il_run = out_ready;
            if (out_ready) begin
               drain_cnt_n = drain_cnt + DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(DRAIN_BEATS - 1)) begin
                  // Running out of symbols without in_last ends the frame as an error.
                  if (last_seen || (sym_q == nsym_q - NSYM_W'(1))) begin
                     state_n = ST_DONE;
                  end else begin
                     state_n     = ST_FILL;
                     sym_n       = sym_q + NSYM_W'(1);
                     beat_cnt_n  = '0;
                     drain_cnt_n = '0;
                  end
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            sym_n   = '0;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign il_mod     = mod_q;
   assign busy       = (state != ST_IDLE);
   assign sym_idx    = sym_q;
   assign frame_done = (state == ST_DONE);
   assign frame_err  = zero_err_q | ((state == ST_DONE) && !last_seen);
   assign dbg_state  = state;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Randomized self-checking bench for interleaver_ctrl against a frame-level
// model that lists the exact sequence of interleaver run beats per frame.
module tb_interleaver_ctrl;
   import interleaver_ctrl_pkg::*;

   localparam int NSYM_W = 10;
   localparam int DB     = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              frame_start = 1'b0;
   logic [1:0]        mod_in = '0;
   logic [NSYM_W-1:0] nsym_in = '0;
   logic              in_valid = 1'b0;
   logic [1:0]        in_x = '0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic              out_ready = 1'b0;
   logic              il_run;
   logic [1:0]        il_x;
   logic [1:0]        il_mod;
   logic              busy;
   logic [NSYM_W-1:0] sym_idx;
   logic              frame_done;
   logic              frame_err;
   state_t            dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] exp_q[$];

   interleaver_ctrl #(.DRAIN_BEATS(DB), .NSYM_W(NSYM_W)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .mod_in(mod_in),
      .nsym_in(nsym_in), .in_valid(in_valid), .in_x(in_x), .in_last(in_last),
      .in_ready(in_ready), .out_ready(out_ready), .il_run(il_run), .il_x(il_x),
      .il_mod(il_mod), .busy(busy), .sym_idx(sym_idx), .frame_done(frame_done),
      .frame_err(frame_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int pairs_of(input int mod);
      case (mod)
         0: return 24;
         1: return 48;
         2: return 96;
         default: return 144;
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      check({tag, "_il_run"}, 32'(il_run), 0);
      check({tag, "_il_x"}, 32'(il_x), 0);
      check({tag, "_il_mod"}, 32'(il_mod), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_sym_idx"}, 32'(sym_idx), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_frame_err"}, 32'(frame_err), 0);
   endtask

   // One frame: npairs data pairs, in_last on the final one if use_last, else
   // exactly nsym*P pairs are offered and the frame must end in error.
   task automatic run_frame(input int mod, input int nsym, input int npairs, input bit use_last,
                            input int vpct, input int rpct, input bit stall5);
      logic [1:0] data[$];
      int p, ns, ptr, runs, fill_cyc, cyc;
      bit done_seen, exp_err;
      p = pairs_of(mod);
      data.delete();
      for (int i = 0; i < npairs; i++) data.push_back(2'($urandom_range(0, 3)));
      ns      = use_last ? (npairs - 1) / p + 1 : nsym;
      exp_err = !use_last;
      exp_q.delete();
      for (int s = 0; s < ns; s++) begin
         for (int k = 0; k < p; k++) exp_q.push_back((s * p + k < npairs) ? data[s * p + k] : 2'b00);
         for (int d = 0; d < DB; d++) exp_q.push_back(2'b00);
      end

      @(posedge clk); #1;
      frame_start = 1'b1; mod_in = 2'(mod); nsym_in = NSYM_W'(nsym);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      mod_in  = (mod == 3) ? 2'd0 : 2'd3;
      nsym_in = NSYM_W'($urandom_range(0, 1023));
      ptr = 0; runs = 0; fill_cyc = -1; done_seen = 1'b0;

      for (cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
         in_valid = (ptr < npairs) && ($urandom_range(0, 99) < vpct);
         in_x     = (ptr < npairs) ? data[ptr] : 2'($urandom_range(0, 3));
         in_last  = in_valid ? (use_last && ptr == npairs - 1) : 1'($urandom_range(0, 1));
         if (stall5 && fill_cyc >= 0 && cyc - fill_cyc <= 5) out_ready = 1'b0;
         else out_ready = ($urandom_range(0, 99) < rpct);
         @(negedge clk);
         if (il_run) begin
            if (exp_q.size() == 0) check("extra_run", 1, 0);
            else check("il_x", 32'(il_x), 32'(exp_q.pop_front()));
            if (ptr >= npairs) check("pad_in_ready", 32'(in_ready), 0);
            runs++;
            if (runs == p && fill_cyc < 0) fill_cyc = cyc;
         end
         if (in_valid && in_ready) ptr++;
         if (frame_done) begin
            done_seen = 1'b1;
            check("frame_err_at_done", 32'(frame_err), 32'(exp_err));
            check("beats_left", 32'(exp_q.size()), 0);
            check("sym_idx_at_done", 32'(sym_idx), 32'(ns - 1));
            check("il_mod_latched", 32'(il_mod), 32'(mod));
            check("pairs_taken", 32'(ptr), 32'(npairs));
            if (stall5) check("drain_len", 32'(cyc - fill_cyc), 14);
         end else begin
            if (frame_err) check("early_frame_err", 1, 0);
            if (!busy) check("busy_mid_frame", 0, 1);
         end
         @(posedge clk); #1;
      end
      if (!done_seen) check("done_timeout", 0, 1);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      check("busy_after", 32'(busy), 0);
      check("sym_idx_after", 32'(sym_idx), 0);
      check("done_after", 32'(frame_done), 0);
   endtask

   initial begin
      int errs;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      #2 rst = 1'b1;

      run_frame(0, 1, 24, 1'b1, 100, 100, 1'b0);
      run_frame(2, 2, 100, 1'b1, 100, 100, 1'b0);
      run_frame(1, 1, 48, 1'b1, 100, 100, 1'b1);
      run_frame(3, 1, 144, 1'b0, 100, 100, 1'b0);

      // nsym=0 start: a single error pulse, controller stays idle
      @(posedge clk); #1;
      frame_start = 1'b1; nsym_in = '0; mod_in = 2'd2;
      @(posedge clk); #1;
      frame_start = 1'b0;
      errs = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (frame_err) errs++;
         check("nsym0_busy", 32'(busy), 0);
         @(negedge clk);
      end
      check("nsym0_err_pulses", 32'(errs), 1);

      // Reset mid-fill aborts immediately, then a normal frame follows
      @(posedge clk); #1;
      frame_start = 1'b1; mod_in = 2'd2; nsym_in = NSYM_W'(2);
      @(posedge clk); #1;
      frame_start = 1'b0; in_valid = 1'b1; in_x = 2'd3; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      check_reset_outputs("midreset_hold");
      in_valid = 1'b0;
      #2 rst = 1'b1;
      run_frame(1, 1, 30, 1'b1, 80, 80, 1'b0);

      for (int f = 0; f < 6; f++) begin
         int m, n, np;
         bit ul;
         m  = $urandom_range(0, 3);
         n  = $urandom_range(1, 3);
         ul = 1'($urandom_range(0, 1));
         np = ul ? $urandom_range(1, n * pairs_of(m)) : n * pairs_of(m);
         run_frame(m, n, np, ul, $urandom_range(50, 100), $urandom_range(50, 100), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
